// File: rtl/limn2600_write_buffer.sv
// limn2600_write_buffer: posted-write FIFO between the Limn2600 CPU bus master
// and the SRAM slave. CPU writes retire in one cycle into a DEPTH-entry queue
// that drains to memory in the background; reads go to memory once ordering is
// safe. Define LIMN2600_WBUF_FORWARD_EN to serve reads from buffered writes and
// to let read misses bypass older buffered writes.
module limn2600_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_cs,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_data_in,
  output logic                     cpu_rdy,
  output logic [DW-1:0]            cpu_data_out,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data_out,
  input  logic [DW-1:0]            mem_data_in,
  input  logic                     mem_rdy,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {C_IDLE, C_ACK, C_RD_WAIT} cpu_state_t;
  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mem_state_t;

  cpu_state_t     c_state;
  mem_state_t     m_state;

  logic [AW-1:0]  addr_q [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           rd_done;
  logic           rd_ok;
  logic           fwd_hit;
  logic [DW-1:0]  fwd_data;

  // Full/empty come from the registered count, so a pop on the same edge
  // never makes room for a push.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = (c_state == C_IDLE) && cpu_cs && cpu_we && !full;
  assign pop      = (m_state == M_WRITE) && mem_rdy;
  assign rd_done  = (m_state == M_READ) && mem_rdy;
  assign wb_count = count;

`ifdef LIMN2600_WBUF_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins; the head
  // stays valid until its drain completes.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (addr_q[head + PW'(k)] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head + PW'(k)];
      end
    end
  end

  // A miss cannot alias any buffered write, so it may overtake them.
  assign rd_ok = 1'b1;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign rd_ok    = empty;
`endif

  // Entry storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_data_in;
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // CPU side: accept writes, resolve reads, and pulse cpu_rdy exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_state      <= C_IDLE;
      cpu_rdy      <= 1'b0;
      cpu_data_out <= '0;
    end else begin
      cpu_rdy <= 1'b0;
      case (c_state)
        C_IDLE: begin
          if (cpu_cs) begin
            if (cpu_we) begin
              if (!full) begin
                cpu_rdy <= 1'b1;
                c_state <= C_ACK;
              end
            end else if (fwd_hit) begin
              cpu_data_out <= fwd_data;
              cpu_rdy      <= 1'b1;
              c_state      <= C_ACK;
            end else begin
              c_state <= C_RD_WAIT;
            end
          end
        end
        C_RD_WAIT: begin
          if (rd_done) begin
            cpu_data_out <= mem_data_in;
            cpu_rdy      <= 1'b1;
            c_state      <= C_ACK;
          end
        end
        C_ACK:   c_state <= C_IDLE;
        default: c_state <= C_IDLE;
      endcase
    end
  end

  // Memory side: pending reads win over draining; every transaction is
  // followed by at least one idle cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state      <= M_IDLE;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if ((c_state == C_RD_WAIT) && rd_ok) begin
            m_state  <= M_READ;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr;
          end else if (!empty) begin
            m_state      <= M_WRITE;
            mem_cs       <= 1'b1;
            mem_we       <= 1'b1;
            mem_addr     <= addr_q[head];
            mem_data_out <= data_q[head];
          end
        end
        M_WRITE, M_READ: begin
          if (mem_rdy) begin
            m_state <= M_IDLE;
            mem_cs  <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_limn2600_write_buffer.sv
// Testbench for limn2600_write_buffer: an SRAM model with configurable wait
// states, a write scoreboard checked at each memory write completion, and a
// read scoreboard checked at each cpu_rdy.
module tb_limn2600_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cpu_cs = 1'b0;
  logic                   cpu_we = 1'b0;
  logic [AW-1:0]          cpu_addr = '0;
  logic [DW-1:0]          cpu_data_in = '0;
  logic                   cpu_rdy;
  logic [DW-1:0]          cpu_data_out;
  logic                   mem_cs;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_data_out;
  logic [DW-1:0]          mem_data_in = '0;
  logic                   mem_rdy = 1'b0;
  logic [$clog2(DEPTH):0] wb_count;

  limn2600_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_cs       (cpu_cs),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_rdy      (cpu_rdy),
    .cpu_data_out (cpu_data_out),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_rdy      (mem_rdy),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] sram      [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  bit          sram_hold    = 1'b0;
  int          sram_wait    = 0;
  int          wcnt         = 0;
  int          wr_done      = 0;
  int          wr_before_rd = 0;
  int          rd_cycles    = 0;

  function automatic logic [31:0] sramInit(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // SRAM model: raises mem_rdy after sram_wait cycles of mem_cs, unless held,
  // and checks each completed write against the scoreboard.
  always @(negedge clk) begin
    if (mem_cs && !mem_we) rd_cycles++;
    if (!mem_cs || sram_hold) begin
      mem_rdy = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= sram_wait) begin
      mem_rdy = 1'b1;
    end else begin
      mem_rdy = 1'b0;
      wcnt++;
    end
    if (mem_cs && !mem_we)
      mem_data_in = sram.exists(mem_addr) ? sram[mem_addr] : sramInit(mem_addr);
    if (mem_cs && mem_rdy) begin
      if (mem_we) begin
        wr_t e;
        sram[mem_addr] = mem_data_out;
        wr_done++;
        checkOutput("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          checkOutput("wr_addr", mem_addr, e.addr);
          checkOutput("wr_data", mem_data_out, e.data);
        end
      end else begin
        wr_before_rd = wr_done;
      end
    end
  end

  // CPU write: hold the request until cpu_rdy, then leave one idle cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input int budget, output int lat);
    exp_wr.push_back('{a, d});
    model_mem[a] = d;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_data_in = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_rdy && lat < budget);
    checkOutput("wr_ack", 64'(cpu_rdy), 64'd1);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  // CPU read: expected data comes from the program-order memory model.
  task automatic cpuRead(input logic [31:0] a, input int budget, output int lat);
    exp_rd.push_back(model_mem.exists(a) ? model_mem[a] : sramInit(a));
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_rdy && lat < budget);
    checkOutput("rd_ack", 64'(cpu_rdy), 64'd1);
    checkOutput("rd_data", cpu_data_out, exp_rd.pop_front());
    cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (!(wb_count == 0 && !mem_cs) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 64'(wb_count == 0 && !mem_cs), 64'd1);
    checkOutput("drain_queue", exp_wr.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int base;

    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_rdy", cpu_rdy, 0);
    checkOutput("rst_mem_cs", mem_cs, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_wb_count", wb_count, 0);
    checkOutput("rst_cpu_data", cpu_data_out, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] drain order");
    sram_wait = 1;
    applyStimulus(32'h100, 32'h11, 20, lat); checkOutput("wr_lat_a", lat, 1);
    applyStimulus(32'h104, 32'h22, 20, lat); checkOutput("wr_lat_b", lat, 1);
    applyStimulus(32'h108, 32'h33, 20, lat); checkOutput("wr_lat_c", lat, 1);
    waitDrain(100);
    checkOutput("drain_count", wb_count, 0);

    $display("[TB] same-address read after posted writes");
    sram_hold = 1'b1;
    applyStimulus(32'h200, 32'hAAAA, 20, lat);
    applyStimulus(32'h200, 32'hBBBB, 20, lat);
`ifdef LIMN2600_WBUF_FORWARD_EN
    base = rd_cycles;
    cpuRead(32'h200, 20, lat);
    checkOutput("fwd_lat", lat, 1);
    checkOutput("fwd_no_mem_read", rd_cycles - base, 0);
    sram_hold = 1'b0;
`else
    sram_hold = 1'b0;
    cpuRead(32'h200, 100, lat);
`endif
    waitDrain(100);

    $display("[TB] fill");
    sram_wait = 0;
    sram_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(32'h1000 + 32'(4 * i), 32'hF00 + 32'(i), 20, lat);
      checkOutput("fill_lat", lat, 1);
    end
    checkOutput("fill_count", wb_count, DEPTH);
    fork
      applyStimulus(32'h1000 + 32'(4 * DEPTH), 32'hF0F, 50, lat);
      begin
        repeat (5) @(negedge clk);
        checkOutput("fill_peak", wb_count, DEPTH);
        checkOutput("fill_stall", cpu_rdy, 0);
        sram_hold = 1'b0;
      end
    join
    checkOutput("fill_late_accept", 64'(lat > 5), 64'd1);
    waitDrain(100);

    $display("[TB] read miss");
    sram_wait = 3;
    base = wr_done;
    applyStimulus(32'h400, 32'h1, 20, lat);
    applyStimulus(32'h404, 32'h2, 20, lat);
    cpuRead(32'h300, 200, lat);
`ifdef LIMN2600_WBUF_FORWARD_EN
    checkOutput("miss_bypass", 64'((wr_before_rd - base) < 2), 64'd1);
`else
    checkOutput("miss_after_writes", wr_before_rd - base, 2);
`endif
    waitDrain(100);

    $display("[TB] reset mid-drain");
    sram_wait = 0;
    sram_hold = 1'b1;
    applyStimulus(32'h800, 32'h81, 20, lat);
    applyStimulus(32'h804, 32'h82, 20, lat);
    applyStimulus(32'h808, 32'h83, 20, lat);
    checkOutput("pre_rst_drain", 64'(mem_cs && mem_we), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_mem_cs", mem_cs, 0);
    checkOutput("rst_mid_count", wb_count, 0);
    exp_wr.delete();
    model_mem.delete(32'h800);
    model_mem.delete(32'h804);
    model_mem.delete(32'h808);
    base = wr_done;
    @(negedge clk);
    rst = 1'b1;
    sram_hold = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("no_wr_after_rst", wr_done - base, 0);

    $display("[TB] wrap-around");
    sram_wait = 2;
    for (int i = 0; i < 3 * DEPTH; i++)
      applyStimulus(32'h2000 + 32'(4 * i), $urandom, 100, lat);
    waitDrain(500);
    cpuRead(32'h2014, 200, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
